// File: rtl/acc_core_pkg.sv
// acc_core_pkg
// Shared types and helpers for the parametrised accumulator core.
//   opcode_t  : 4-bit instruction opcodes (0x0..0xF)
//   state_t   : control FSM states
//   instr_width()   : instruction word width for a given data width
//   reg_sel_width() : register-select width for a given register count
package acc_core_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_ADDI  = 4'h6,
        OP_SUBI  = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_STI   = 4'hA,
        OP_MOV   = 4'hB,
        OP_MVA   = 4'hC,
        OP_JMP   = 4'hD,
        OP_JZ    = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // {opcode, op1, op2} with the opcode in the MSBs
    function automatic int instr_width(input int data_w);
        return OPCODE_W + 2 * data_w;
    endfunction

    function automatic int reg_sel_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/acc_core_alu.sv
// acc_core_alu
// Combinational ALU for the accumulator core.
//   acc     in  DATA_W  current accumulator
//   operand in  DATA_W  register value or immediate
//   opcode  in  4       instruction opcode
//   result  out DATA_W  truncated result
//   carry   out 1       carry-out (add), borrow (sub), 0 for logic ops
//   zero    out 1       result == 0
module acc_core_alu
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  opcode_t           opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, operand};

    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB, OP_SUBI: begin
                result = acc - operand;
                carry  = (acc < operand);
            end
            OP_AND: result = acc & operand;
            OP_OR:  result = acc | operand;
            OP_XOR: result = acc ^ operand;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_core_param.sv
// acc_core_param
// Parametrised multi-cycle accumulator core with req/ack instruction and
// data memory ports, status flags, branches and run/halt control.
// Optional feature macro: ACC_CORE_BRANCH_EN (JMP/JZ executed when defined,
// decoded as NOP otherwise).
// Ports:
//   clk, reset (async, active-high), run        : control
//   imem_req/imem_addr/imem_ack/imem_data       : instruction fetch port
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/
//   dmem_ack/dmem_rdata                         : data memory port
//   acc_out, pc_out, zero_flag, carry_flag,
//   halted                                      : observability
module acc_core_param
    import acc_core_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int PC_W    = 8,
    parameter  int NREGS   = 4,
    localparam int INSTR_W = instr_width(DATA_W)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  acc_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               halted
);

    localparam int SEL_W = reg_sel_width(NREGS);

    state_t               state_reg;
    logic [PC_W-1:0]      pc_reg;
    logic [DATA_W-1:0]    acc_reg;
    logic                 zero_reg;
    logic                 carry_reg;
    logic                 halted_reg;
    logic                 imem_req_reg;
    logic                 dmem_req_reg;
    logic                 dmem_we_reg;
    logic [DATA_W-1:0]    dmem_addr_reg;
    logic [DATA_W-1:0]    dmem_wdata_reg;
    logic [INSTR_W-1:0]   ir_reg;
    logic [DATA_W-1:0]    operand_reg;
    logic [DATA_W-1:0]    regs [NREGS];

    // Instruction fields
    opcode_t              opcode;
    logic [DATA_W-1:0]    op1;
    logic [DATA_W-1:0]    op2;
    logic [SEL_W-1:0]     reg_sel;

    assign opcode  = opcode_t'(ir_reg[INSTR_W-1 -: OPCODE_W]);
    assign op1     = ir_reg[2*DATA_W-1 -: DATA_W];
    assign op2     = ir_reg[DATA_W-1:0];
    assign reg_sel = op1[SEL_W-1:0];

    // ALU: immediate forms take op1, register forms the value read in DECODE
    logic [DATA_W-1:0]    alu_operand;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_carry;
    logic                 alu_zero;
    logic                 is_alu;

    assign alu_operand = (opcode == OP_ADDI || opcode == OP_SUBI) ? op1 : operand_reg;
    assign is_alu      = (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                         OP_ADDI, OP_SUBI});

    acc_core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc     (acc_reg),
        .operand (alu_operand),
        .opcode  (opcode),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero)
    );

    // Next PC when leaving EXEC for a non-memory instruction
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      pc_next_exec;

    assign pc_inc = pc_reg + PC_W'(1);

`ifdef ACC_CORE_BRANCH_EN
    logic                 branch_taken;

    assign branch_taken = (opcode == OP_JMP) || (opcode == OP_JZ && zero_reg);
    assign pc_next_exec = branch_taken ? PC_W'(op1) : pc_inc;
`else
    assign pc_next_exec = pc_inc;
`endif

    // Register file: MOV/MVA write in EXEC, one-hot write enable per entry
    logic                 reg_write;
    logic [DATA_W-1:0]    reg_wdata;
    logic [NREGS-1:0]     reg_we;

    assign reg_write = (state_reg == ST_EXEC) && (opcode == OP_MOV || opcode == OP_MVA);
    assign reg_wdata = (opcode == OP_MVA) ? acc_reg : op2;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_we
            assign reg_we[gi] = reg_write && (reg_sel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_we[i]) regs[i] <= reg_wdata;
            end
        end
    end

    // Control FSM. Requests are registered: they rise on entry to FETCH/MEM
    // and fall on the edge that consumes the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= '0;
            acc_reg        <= '0;
            zero_reg       <= 1'b0;
            carry_reg      <= 1'b0;
            halted_reg     <= 1'b0;
            imem_req_reg   <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            ir_reg         <= '0;
            operand_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg    <= ST_FETCH;
                        imem_req_reg <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_reg       <= imem_data;
                        imem_req_reg <= 1'b0;
                        state_reg    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    operand_reg <= regs[reg_sel];
                    state_reg   <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_STI: begin
                            dmem_req_reg  <= 1'b1;
                            dmem_we_reg   <= (opcode != OP_LOAD);
                            dmem_addr_reg <= op1;
                            // STORE sends the accumulator as it was before this instruction
                            if (opcode == OP_STORE) dmem_wdata_reg <= acc_reg;
                            if (opcode == OP_STI)   dmem_wdata_reg <= op2;
                            state_reg     <= ST_MEM;
                        end
                        OP_HALT: begin
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALT;
                        end
                        default: begin
                            if (is_alu) begin
                                acc_reg   <= alu_result;
                                zero_reg  <= alu_zero;
                                carry_reg <= alu_carry;
                            end
                            pc_reg       <= pc_next_exec;
                            imem_req_reg <= 1'b1;
                            state_reg    <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_reg <= 1'b0;
                        dmem_we_reg  <= 1'b0;
                        if (!dmem_we_reg) begin
                            acc_reg  <= dmem_rdata;
                            zero_reg <= (dmem_rdata == '0);
                        end
                        pc_reg       <= pc_inc;
                        imem_req_reg <= 1'b1;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign acc_out    = acc_reg;
    assign pc_out     = pc_reg;
    assign zero_flag  = zero_reg;
    assign carry_flag = carry_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_acc_core_param.sv
// tb_acc_core_param
// Self-checking bench for acc_core_param (DATA_W=8, PC_W=4, NREGS=4).
// Behavioural memories with programmable ack latency, an instruction-level
// reference model, table vectors, hand sequences and random programs.
// Honors ACC_CORE_BRANCH_EN for branch expectations.
module tb_acc_core_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [19:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack;
    logic [7:0]  dmem_rdata;
    logic [7:0]  acc_out;
    logic [3:0]  pc_out;
    logic        zero_flag;
    logic        carry_flag;
    logic        halted;

    acc_core_param #(.DATA_W(8), .PC_W(4), .NREGS(4)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .acc_out(acc_out), .pc_out(pc_out), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // ---------------- memories ----------------
    logic [19:0] imem [16];
    logic [7:0]  dmem [256];
    logic [7:0]  dm_init [256];
    logic        dm_load = 1'b0;
    int          ilat = 0, dlat = 0;
    int          icnt = 0, dcnt = 0;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign imem_ack   = imem_req && (icnt == ilat);
    assign dmem_ack   = dmem_req && (dcnt == dlat);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dm_load) dmem <= dm_init;
        else if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // Data request burst monitor: length and stability during the wait
    logic        mon_clear = 1'b0;
    logic        in_b = 1'b0;
    int          dlen = 0;
    logic        dcorrupt = 1'b0;
    logic [34:0] dsnap = '0;
    logic [34:0] dcur;
    assign dcur = {acc_out, carry_flag, zero_flag, dmem_we, dmem_addr, dmem_wdata, pc_out, 1'b0};

    always @(negedge clk) begin
        if (mon_clear) begin
            in_b <= 1'b0; dlen <= 0; dcorrupt <= 1'b0;
        end else if (dmem_req) begin
            if (!in_b) begin
                in_b <= 1'b1; dlen <= 1; dsnap <= dcur;
            end else begin
                dlen <= dlen + 1;
                if (dsnap != dcur) dcorrupt <= 1'b1;
            end
        end else begin
            in_b <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int op, input int a, input int b);
        return {4'(op), 8'(a), 8'(b)};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) imem[i] = mk(15, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; dm_load = 1'b1; mon_clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; dm_load = 1'b0; mon_clear = 1'b0;
    endtask

    // Reset, pulse run, count edges after the run edge until halted
    task automatic run_prog(output int cyc);
        do_reset();
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        cyc = 0;
        while (!halted && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("halted", 32'(halted), 32'd1);
    endtask

    // ---------------- reference model (instruction level) ----------------
    int         m_acc, m_c, m_z, m_pc, m_cyc, m_halt;
    logic [7:0] m_dm [256];

    task automatic model_run();
        int regs [4];
        int pc, op, a, b, r, nxt;
        logic br_en;
`ifdef ACC_CORE_BRANCH_EN
        br_en = 1'b1;
`else
        br_en = 1'b0;
`endif
        for (int i = 0; i < 4; i++) regs[i] = 0;
        for (int i = 0; i < 256; i++) m_dm[i] = dm_init[i];
        m_acc = 0; m_c = 0; m_z = 0; pc = 0; m_cyc = 0; m_halt = 0;
        for (int s = 0; s < 64; s++) begin
            op = int'(imem[pc][19:16]);
            a  = int'(imem[pc][15:8]);
            b  = int'(imem[pc][7:0]);
            r  = regs[a % 4];
            m_cyc += 3 + ilat;
            nxt = (pc + 1) % 16;
            case (op)
                1, 6: begin
                    if (op == 6) r = a;
                    m_c = (m_acc + r > 255) ? 1 : 0;
                    m_acc = (m_acc + r) % 256; m_z = (m_acc == 0) ? 1 : 0;
                end
                2, 7: begin
                    if (op == 7) r = a;
                    m_c = (m_acc < r) ? 1 : 0;
                    m_acc = (m_acc - r + 256) % 256; m_z = (m_acc == 0) ? 1 : 0;
                end
                3: begin m_acc = m_acc & r; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
                4: begin m_acc = m_acc | r; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
                5: begin m_acc = m_acc ^ r; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
                8: begin m_cyc += 1 + dlat; m_acc = int'(m_dm[a]); m_z = (m_acc == 0) ? 1 : 0; end
                9: begin m_cyc += 1 + dlat; m_dm[a] = 8'(m_acc); end
                10: begin m_cyc += 1 + dlat; m_dm[a] = 8'(b); end
                11: regs[a % 4] = b;
                12: regs[a % 4] = m_acc;
                13: if (br_en) nxt = a % 16;
                14: if (br_en && m_z == 1) nxt = a % 16;
                15: m_halt = 1;
                default: ;
            endcase
            if (m_halt == 1) break;
            pc = nxt;
        end
        m_pc = pc;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int         op;
        logic [7:0] init;
        logic [7:0] opnd;
        logic [7:0] e_acc;
        logic       e_c;
        logic       e_z;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int cyc;
        int miss;
        int op, a, b;

        vecs[0]  = '{1,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{1,  8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
        vecs[2]  = '{2,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{2,  8'h07, 8'h07, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[5]  = '{4,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{5,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{6,  8'hFF, 8'h02, 8'h01, 1'b1, 1'b0};
        vecs[8]  = '{7,  8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{7,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{0,  8'h42, 8'h00, 8'h42, 1'b0, 1'b0};

        for (int i = 0; i < 256; i++) dm_init[i] = 8'h00;
        fill_halt();

        // Reset mid-fetch with the ack withheld
        imem[0] = mk(6, 5, 0);
        imem[1] = mk(0, 0, 0);
        ilat = 0; dlat = 0;
        do_reset();
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        repeat (3) @(posedge clk);
        #1; ilat = 100;
        @(negedge clk);
        chk("fetch_req_held", 32'(imem_req), 32'd1);
        chk("acc_before_reset", 32'(acc_out), 32'h05);
        repeat (2) @(posedge clk);
        #2; reset = 1'b1;
        #1;
        chk("req_drop_async", 32'(imem_req), 32'd0);
        chk("reset_outputs",
            {8'h0, acc_out, pc_out, zero_flag, carry_flag, halted, dmem_req, dmem_we, dmem_wdata, 1'b0},
            32'h0);
        ilat = 0;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_without_run", 32'(imem_req), 32'd0);
        chk("idle_pc", 32'(pc_out), 32'd0);

        // ADDI 5, ADDI 3, HALT
        fill_halt();
        imem[0] = mk(6, 5, 0); imem[1] = mk(6, 3, 0);
        run_prog(cyc);
        $display("seq addi5_addi3: acc=%0h pc=%0d cycles=%0d", acc_out, pc_out, cyc);
        chk("addi_acc", 32'(acc_out), 32'h08);
        chk("addi_zero", 32'(zero_flag), 32'd0);
        chk("addi_pc", 32'(pc_out), 32'd2);
        chk("addi_cycles", 32'(cyc), 32'd9);
        chk("halt_no_req", 32'({imem_req, dmem_req}), 32'd0);

        // ADDI FF, ADDI 02, SUBI 02
        fill_halt();
        imem[0] = mk(6, 8'hFF, 0); imem[1] = mk(6, 2, 0); imem[2] = mk(7, 2, 0);
        run_prog(cyc);
        $display("seq carry_borrow: acc=%0h c=%0b z=%0b", acc_out, carry_flag, zero_flag);
        chk("borrow_acc", 32'(acc_out), 32'hFF);
        chk("borrow_carry", 32'(carry_flag), 32'd1);
        chk("borrow_zero", 32'(zero_flag), 32'd0);

        // STI [10]<-A5, LOAD 10 with 3 wait cycles on dmem
        fill_halt();
        imem[0] = mk(6, 8'hFF, 0); imem[1] = mk(6, 2, 0);
        imem[2] = mk(10, 8'h10, 8'hA5); imem[3] = mk(8, 8'h10, 0);
        dlat = 3;
        run_prog(cyc);
        $display("seq sti_load: acc=%0h c=%0b burst=%0d cycles=%0d", acc_out, carry_flag, dlen, cyc);
        chk("load_acc", 32'(acc_out), 32'hA5);
        chk("load_carry_kept", 32'(carry_flag), 32'd1);
        chk("load_zero", 32'(zero_flag), 32'd0);
        chk("dmem_req_len", 32'(dlen), 32'd4);
        chk("wait_stable", 32'(dcorrupt), 32'd0);
        chk("sti_written", 32'(dmem[8'h10]), 32'hA5);
        chk("mem_cycles", 32'(cyc), 32'd23);
        chk("mem_pc", 32'(pc_out), 32'd4);
        dlat = 0;

        // MOV r2<-7, SUBI 0, JZ 6
        fill_halt();
        imem[0] = mk(11, 2, 7); imem[1] = mk(7, 0, 0); imem[2] = mk(14, 6, 0);
        imem[4] = mk(0, 0, 0); imem[5] = mk(0, 0, 0);
        run_prog(cyc);
        $display("seq jz: pc=%0d z=%0b cycles=%0d", pc_out, zero_flag, cyc);
        chk("jz_zero", 32'(zero_flag), 32'd1);
`ifdef ACC_CORE_BRANCH_EN
        chk("jz_pc", 32'(pc_out), 32'd6);
`else
        chk("jz_pc", 32'(pc_out), 32'd3);
`endif
        chk("jz_cycles", 32'(cyc), 32'd12);

        // Sixteen NOPs: pc wraps 15 -> 0 and fetch of address 0 is reissued
        for (int i = 0; i < 16; i++) imem[i] = mk(0, 0, 0);
        do_reset();
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("wrap_pc15", 32'(pc_out), 32'd15);
        repeat (3) @(posedge clk);
        #1;
        $display("seq wrap: pc=%0d imem_req=%0b imem_addr=%0d", pc_out, imem_req, imem_addr);
        chk("wrap_pc0", 32'(pc_out), 32'd0);
        chk("wrap_refetch", 32'({imem_req, imem_addr}), 32'h10);

        // Table vectors: ADDI init; MOV r1<-opnd; OP; HALT
        for (int v = 0; v < 11; v++) begin
            fill_halt();
            imem[0] = mk(6, int'(vecs[v].init), 0);
            imem[1] = mk(11, 1, int'(vecs[v].opnd));
            if (vecs[v].op >= 1 && vecs[v].op <= 5) imem[2] = mk(vecs[v].op, 1, 0);
            else if (vecs[v].op == 6 || vecs[v].op == 7) imem[2] = mk(vecs[v].op, int'(vecs[v].opnd), 0);
            else imem[2] = mk(0, 0, 0);
            run_prog(cyc);
            $display("vec %0d op=%0h %0h,%0h: acc=%0h c=%0b z=%0b", v, vecs[v].op,
                     vecs[v].init, vecs[v].opnd, acc_out, carry_flag, zero_flag);
            chk($sformatf("vec%0d_acc", v), 32'(acc_out), 32'(vecs[v].e_acc));
            chk($sformatf("vec%0d_carry", v), 32'(carry_flag), 32'(vecs[v].e_c));
            chk($sformatf("vec%0d_zero", v), 32'(zero_flag), 32'(vecs[v].e_z));
            chk($sformatf("vec%0d_pc", v), 32'(pc_out), 32'd3);
        end

        // Random programs against the reference model
        for (int t = 0; t < 20; t++) begin
            for (int p = 0; p < 15; p++) begin
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                if (op >= 8 && op <= 10) a = $urandom_range(0, 15);
                if (op == 13 || op == 14) a = $urandom_range(p + 1, 15);
                imem[p] = mk(op, a, b);
            end
            imem[15] = mk(15, 0, 0);
            for (int i = 0; i < 256; i++) dm_init[i] = 8'($urandom_range(0, 255));
            ilat = $urandom_range(0, 3);
            dlat = $urandom_range(0, 3);
            model_run();
            run_prog(cyc);
            miss = 0;
            for (int i = 0; i < 256; i++) if (dmem[i] !== m_dm[i]) miss++;
            $display("rand %0d ilat=%0d dlat=%0d: acc=%0h c=%0b z=%0b pc=%0d cycles=%0d",
                     t, ilat, dlat, acc_out, carry_flag, zero_flag, pc_out, cyc);
            chk("rand_acc", 32'(acc_out), 32'(m_acc));
            chk("rand_carry", 32'(carry_flag), 32'(m_c));
            chk("rand_zero", 32'(zero_flag), 32'(m_z));
            chk("rand_pc", 32'(pc_out), 32'(m_pc));
            chk("rand_cycles", 32'(cyc), 32'(m_cyc));
            chk("rand_dmem_diffs", 32'(miss), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
